// File: rtl/decode_unit.sv
// RV32I/RV32E decode stage with register file, valid/ready handshake, load-use interlock.
// Optional Zicsr decode is enabled by defining DECODE_ZICSR_EN.
module decode_unit #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int LU_STALL = 1,
   parameter int ALUOPS   = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_inst,
   input  logic [XLEN-1:0]   i_pc,
   input  logic              i_wr_en,
   input  logic [4:0]        i_wr_addr,
   input  logic [XLEN-1:0]   i_wr_data,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [6:0]        o_opcode,
   output logic [4:0]        o_rd_addr,
   output logic [4:0]        o_rs1_addr,
   output logic [4:0]        o_rs2_addr,
   output logic [XLEN-1:0]   o_rs1_data,
   output logic [XLEN-1:0]   o_rs2_data,
   output logic [XLEN-1:0]   o_imm,
   output logic [2:0]        o_funct3,
   output logic [6:0]        o_funct7,
   output logic [ALUOPS-1:0] o_alu_op,
   output logic [XLEN-1:0]   o_pc,
   output logic              o_wb_en,
   output logic              o_illegal,
   output logic              o_csr
);

   localparam int AW = $clog2(NREG);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [ALUOPS-1:0] ALU_NONE = ALUOPS'(0);
   localparam logic [ALUOPS-1:0] ALU_ADD  = ALUOPS'(1);
   localparam logic [ALUOPS-1:0] ALU_SUB  = ALUOPS'(2);
   localparam logic [ALUOPS-1:0] ALU_SLL  = ALUOPS'(3);
   localparam logic [ALUOPS-1:0] ALU_SLT  = ALUOPS'(4);
   localparam logic [ALUOPS-1:0] ALU_SLTU = ALUOPS'(5);
   localparam logic [ALUOPS-1:0] ALU_XOR  = ALUOPS'(6);
   localparam logic [ALUOPS-1:0] ALU_SRL  = ALUOPS'(7);
   localparam logic [ALUOPS-1:0] ALU_SRA  = ALUOPS'(8);
   localparam logic [ALUOPS-1:0] ALU_OR   = ALUOPS'(9);
   localparam logic [ALUOPS-1:0] ALU_AND  = ALUOPS'(10);
   localparam logic [ALUOPS-1:0] ALU_EQ   = ALUOPS'(11);
   localparam logic [ALUOPS-1:0] ALU_NE   = ALUOPS'(12);
   localparam logic [ALUOPS-1:0] ALU_LT   = ALUOPS'(13);
   localparam logic [ALUOPS-1:0] ALU_GE   = ALUOPS'(14);
   localparam logic [ALUOPS-1:0] ALU_LTU  = ALUOPS'(15);
   localparam logic [ALUOPS-1:0] ALU_GEU  = ALUOPS'(16);

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic reg_oob(input logic [4:0] a);
      return 32'(a) >= NREG;
   endfunction

   function automatic logic [ALUOPS-1:0] arith_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  arith_op = ALU_SLL;
         3'b010:  arith_op = ALU_SLT;
         3'b011:  arith_op = ALU_SLTU;
         3'b100:  arith_op = ALU_XOR;
         3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  arith_op = ALU_OR;
         default: arith_op = ALU_AND;
      endcase
   endfunction

   // Register state
   logic [XLEN-1:0]   rf_q [NREG];
   logic [XLEN-1:0]   rf_d [NREG];
   logic              valid_q, valid_d;
   logic [1:0]        hcnt_q, hcnt_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [4:0]        rd_addr_q, rd_addr_d, rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
   logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [6:0]        funct7_q, funct7_d;
   logic [ALUOPS-1:0] alu_op_q, alu_op_d;
   logic              wb_en_q, wb_en_d, illegal_q, illegal_d, csr_q, csr_d;
   logic              uimm_q, uimm_d;

   // Combinational decode of the incoming instruction
   logic [6:0]        dec_op, dec_f7;
   logic [4:0]        dec_rd, dec_rs1, dec_rs2;
   logic [2:0]        dec_f3;
   logic [XLEN-1:0]   dec_imm, rd1_data, rd2_data;
   logic [ALUOPS-1:0] dec_alu;
   logic              dec_wb, dec_ill, dec_csr, dec_uimm;
   logic              use_rd, use_rs1, use_rs2;
   logic              hazard, in_fire, out_fire, ready;

   assign dec_op  = i_inst[6:0];
   assign dec_rd  = i_inst[11:7];
   assign dec_f3  = i_inst[14:12];
   assign dec_rs1 = i_inst[19:15];
   assign dec_rs2 = i_inst[24:20];
   assign dec_f7  = i_inst[31:25];

   always_comb begin
      dec_imm  = '0;
      dec_alu  = ALU_NONE;
      dec_wb   = 1'b0;
      dec_ill  = 1'b0;
      dec_csr  = 1'b0;
      dec_uimm = 1'b0;
      use_rd   = 1'b0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      case (dec_op)
         OP_LUI, OP_AUIPC: begin
            dec_imm = sext32({i_inst[31:12], 12'b0});
            dec_alu = ALU_ADD;
            dec_wb  = 1'b1;
            use_rd  = 1'b1;
         end
         OP_JAL: begin
            dec_imm = sext32({{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                              i_inst[30:21], 1'b0});
            dec_alu = ALU_ADD;
            dec_wb  = 1'b1;
            use_rd  = 1'b1;
         end
         OP_JALR: begin
            dec_imm = sext32({{20{i_inst[31]}}, i_inst[31:20]});
            dec_alu = ALU_ADD;
            dec_wb  = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            dec_ill = (dec_f3 != 3'b000);
         end
         OP_BRANCH: begin
            dec_imm = sext32({{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                              i_inst[11:8], 1'b0});
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            case (dec_f3)
               3'b000:  dec_alu = ALU_EQ;
               3'b001:  dec_alu = ALU_NE;
               3'b100:  dec_alu = ALU_LT;
               3'b101:  dec_alu = ALU_GE;
               3'b110:  dec_alu = ALU_LTU;
               3'b111:  dec_alu = ALU_GEU;
               default: dec_ill = 1'b1;
            endcase
         end
         OP_LOAD: begin
            dec_imm = sext32({{20{i_inst[31]}}, i_inst[31:20]});
            dec_alu = ALU_ADD;
            dec_wb  = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            dec_ill = (dec_f3 == 3'b011) || (dec_f3 == 3'b110) || (dec_f3 == 3'b111);
         end
         OP_STORE: begin
            dec_imm = sext32({{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]});
            dec_alu = ALU_ADD;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            dec_ill = (dec_f3[2] || dec_f3 == 3'b011);
         end
         OP_IMM: begin
            dec_imm = sext32({{20{i_inst[31]}}, i_inst[31:20]});
            dec_wb  = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            dec_alu = arith_op(dec_f3, (dec_f3 == 3'b101) && (dec_f7 == 7'b0100000));
            // Shift-immediates carry shamt in [24:20]; the upper bits must be a valid funct7
            if (dec_f3 == 3'b001)
               dec_ill = (dec_f7 != 7'b0000000);
            else if (dec_f3 == 3'b101)
               dec_ill = (dec_f7 != 7'b0000000) && (dec_f7 != 7'b0100000);
         end
         OP_REG: begin
            dec_wb  = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            dec_alu = arith_op(dec_f3, dec_f7 == 7'b0100000);
            if (dec_f7 == 7'b0100000)
               dec_ill = (dec_f3 != 3'b000) && (dec_f3 != 3'b101);
            else
               dec_ill = (dec_f7 != 7'b0000000);
         end
`ifdef DECODE_ZICSR_EN
         OP_SYSTEM: begin
            if (dec_f3 != 3'b000 && dec_f3 != 3'b100) begin
               dec_csr  = 1'b1;
               dec_imm  = XLEN'(i_inst[31:20]);
               dec_wb   = 1'b1;
               use_rd   = 1'b1;
               use_rs1  = !dec_f3[2];
               dec_uimm = dec_f3[2];
            end else if (dec_f3 == 3'b000 && i_inst[19:7] == 13'd0 &&
                         (i_inst[31:20] == 12'h000 || i_inst[31:20] == 12'h001)) begin
               dec_imm = XLEN'(i_inst[31:20]);
            end else begin
               dec_ill = 1'b1;
            end
         end
`else
         OP_SYSTEM: dec_ill = 1'b1;
`endif
         default: dec_ill = 1'b1;
      endcase
      if ((use_rd && reg_oob(dec_rd)) || (use_rs1 && reg_oob(dec_rs1)) ||
          (use_rs2 && reg_oob(dec_rs2)))
         dec_ill = 1'b1;
      if (dec_ill) begin
         dec_alu = ALU_NONE;
         dec_wb  = 1'b0;
      end else begin
         dec_wb = dec_wb && (dec_rd != 5'd0);
      end
   end

   // Register file read with write-through bypass; x0 and absent registers read 0
   always_comb begin
      rd1_data = '0;
      rd2_data = '0;
      if (dec_uimm)
         rd1_data = XLEN'(dec_rs1);
      else if (dec_rs1 != 5'd0 && !reg_oob(dec_rs1))
         rd1_data = (i_wr_en && i_wr_addr == dec_rs1) ? i_wr_data : rf_q[dec_rs1[AW-1:0]];
      if (dec_rs2 != 5'd0 && !reg_oob(dec_rs2))
         rd2_data = (i_wr_en && i_wr_addr == dec_rs2) ? i_wr_data : rf_q[dec_rs2[AW-1:0]];
   end

   always_comb begin
      rf_d = rf_q;
      if (i_wr_en && i_wr_addr != 5'd0 && !reg_oob(i_wr_addr))
         rf_d[i_wr_addr[AW-1:0]] = i_wr_data;
   end

   // Handshake and load-use interlock
   always_comb begin
      out_fire = valid_q && i_ready;
      hazard   = out_fire && (opcode_q == OP_LOAD) && (rd_addr_q != 5'd0) && i_valid &&
                 ((use_rs1 && dec_rs1 == rd_addr_q) || (use_rs2 && dec_rs2 == rd_addr_q));
      ready    = i_rst_n && !i_flush && (hcnt_q == 2'd0) && (!valid_q || i_ready) && !hazard;
      in_fire  = i_valid && ready;
   end

   assign o_ready = ready;

   always_comb begin
      valid_d    = valid_q;
      hcnt_d     = (hcnt_q != 2'd0) ? hcnt_q - 2'd1 : 2'd0;
      opcode_d   = opcode_q;
      rd_addr_d  = rd_addr_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      funct3_d   = funct3_q;
      funct7_d   = funct7_q;
      alu_op_d   = alu_op_q;
      wb_en_d    = wb_en_q;
      illegal_d  = illegal_q;
      csr_d      = csr_q;
      uimm_d     = uimm_q;
      // A held instruction must still see write-backs that land while it waits
      if (valid_q && !i_ready && i_wr_en && i_wr_addr != 5'd0) begin
         if (i_wr_addr == rs1_addr_q && !uimm_q)
            rs1_data_d = i_wr_data;
         if (i_wr_addr == rs2_addr_q)
            rs2_data_d = i_wr_data;
      end
      if (i_flush) begin
         valid_d = 1'b0;
         hcnt_d  = 2'd0;
      end else if (hazard) begin
         valid_d = 1'b0;
         hcnt_d  = 2'(LU_STALL - 1);
      end else if (in_fire) begin
         valid_d    = 1'b1;
         opcode_d   = dec_op;
         rd_addr_d  = dec_rd;
         rs1_addr_d = dec_rs1;
         rs2_addr_d = dec_rs2;
         rs1_data_d = rd1_data;
         rs2_data_d = rd2_data;
         imm_d      = dec_imm;
         pc_d       = i_pc;
         funct3_d   = dec_f3;
         funct7_d   = dec_f7;
         alu_op_d   = dec_alu;
         wb_en_d    = dec_wb;
         illegal_d  = dec_ill;
         csr_d      = dec_csr;
         uimm_d     = dec_uimm;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         valid_q    <= 1'b0;
         hcnt_q     <= 2'd0;
         opcode_q   <= '0;
         rd_addr_q  <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         alu_op_q   <= '0;
         wb_en_q    <= 1'b0;
         illegal_q  <= 1'b0;
         csr_q      <= 1'b0;
         uimm_q     <= 1'b0;
      end else begin
         rf_q       <= rf_d;
         valid_q    <= valid_d;
         hcnt_q     <= hcnt_d;
         opcode_q   <= opcode_d;
         rd_addr_q  <= rd_addr_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         funct3_q   <= funct3_d;
         funct7_q   <= funct7_d;
         alu_op_q   <= alu_op_d;
         wb_en_q    <= wb_en_d;
         illegal_q  <= illegal_d;
         csr_q      <= csr_d;
         uimm_q     <= uimm_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_opcode   = opcode_q;
   assign o_rd_addr  = rd_addr_q;
   assign o_rs1_addr = rs1_addr_q;
   assign o_rs2_addr = rs2_addr_q;
   assign o_rs1_data = rs1_data_q;
   assign o_rs2_data = rs2_data_q;
   assign o_imm      = imm_q;
   assign o_funct3   = funct3_q;
   assign o_funct7   = funct7_q;
   assign o_alu_op   = alu_op_q;
   assign o_pc       = pc_q;
   assign o_wb_en    = wb_en_q;
   assign o_illegal  = illegal_q;
   assign o_csr      = csr_q;

endmodule
